// File: rtl/rx_pkg.sv
// rx_pkg: shared widths, frame geometry and writer state type for the Rx frame-buffer controller
package rx_pkg;
  localparam int ADD_W = 18;
  localparam int DATA_W = 6;
  localparam logic [17:0] FRAME_SIZE = 18'h12C00;
  localparam logic [17:0] LAST_ADD = FRAME_SIZE - 18'd1;
  typedef enum logic {IDLE, WRITE} wrState_t;
endpackage

// File: rtl/rx_bank_swap.sv
// rx_bank_swap: writer FSM plus wr/rd bank, frame_ready and drop counter state
// Ports: clk, rst (async, active-high); rxFrameStart, wrStrobe, wrAdd from Rx decode;
// rdFrameStart from the display; wrAccept/wrBankNow steer this cycle's write;
// rdBank, frameReady, dropCnt are the registered bank-swap state.
module rx_bank_swap #(
  parameter int ADD_W = rx_pkg::ADD_W,
  parameter logic [ADD_W-1:0] LAST_ADD = rx_pkg::LAST_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxFrameStart,
  input  logic             wrStrobe,
  input  logic [ADD_W-1:0] wrAdd,
  input  logic             rdFrameStart,
  output logic             wrAccept,
  output logic             wrBankNow,
  output logic             rdBank,
  output logic             frameReady,
  output logic [7:0]       dropCnt
);
  import rx_pkg::*;
  wrState_t state, stateNext;
  logic wrBank, idle, swapNow, startNew, drop, done;
  always_comb begin
    idle = state == IDLE;
    swapNow = rdFrameStart & frameReady & idle;
    startNew = rxFrameStart & idle;
    // a swap in the same cycle means the pending frame was shown, so it is not a drop
    drop = startNew & frameReady & ~swapNow;
    // a frame header with a strobe opens the frame first, so that write is accepted
    wrAccept = wrStrobe & (rxFrameStart | ~idle);
    wrBankNow = startNew ? ~(rdBank ^ swapNow) : wrBank;
    done = wrAccept & (wrAdd == LAST_ADD);
    stateNext = done ? IDLE : rxFrameStart ? WRITE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wrBank <= 1'b0;
      rdBank <= 1'b0;
      frameReady <= 1'b0;
      dropCnt <= 8'd0;
    end else begin
      state <= stateNext;
      wrBank <= wrBankNow;
      rdBank <= rdBank ^ swapNow;
      frameReady <= done | (frameReady & ~swapNow & ~drop);
      if (drop && dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
    end
  end
endmodule

// File: rtl/rx_bank_arbiter.sv
// rx_bank_arbiter: ping-pong frame-buffer port arbiter between Rx writes and display reads
// Ports: clk, rst (async, active-high); rx_* write side; rd_* display read side with
// rd_ack/rd_valid/rd_data; mem_* single-port dual-bank RAM interface; rd_bank,
// frame_ready and drop_cnt status.
module rx_bank_arbiter #(
  parameter int ADD_W = rx_pkg::ADD_W,
  parameter int DATA_W = rx_pkg::DATA_W,
  parameter logic [ADD_W-1:0] LAST_ADD = rx_pkg::LAST_ADD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_frame_start,
  input  logic              rx_wr_y,
  input  logic              rx_wr_c,
  input  logic [ADD_W-1:0]  rx_wr_add,
  input  logic [DATA_W-1:0] rx_wr_data,
  input  logic              rd_frame_start,
  input  logic              rd_req,
  input  logic [ADD_W-1:0]  rd_add,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_sel_c,
  output logic              mem_bank,
  output logic [ADD_W-1:0]  mem_add,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic [7:0]        drop_cnt
);
  import rx_pkg::*;
  logic wrAccept, wrBank, grant;
  // rd_req stays high through the ack cycle, so an outstanding ack blocks a second grant
  assign grant = rd_req & ~rd_ack & ~wrAccept;
  rx_bank_swap #(.ADD_W(ADD_W), .LAST_ADD(LAST_ADD)) bankSwap (
    .clk(clk),
    .rst(rst),
    .rxFrameStart(rx_frame_start),
    .wrStrobe(rx_wr_y | rx_wr_c),
    .wrAdd(rx_wr_add),
    .rdFrameStart(rd_frame_start),
    .wrAccept(wrAccept),
    .wrBankNow(wrBank),
    .rdBank(rd_bank),
    .frameReady(frame_ready),
    .dropCnt(drop_cnt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_sel_c <= 1'b0;
      mem_bank <= 1'b0;
      mem_add <= '0;
      mem_wdata <= '0;
      rd_ack <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      mem_en <= wrAccept | grant;
      mem_we <= wrAccept;
      mem_sel_c <= wrAccept & ~rx_wr_y;
      mem_bank <= wrAccept ? wrBank : grant & rd_bank;
      mem_add <= wrAccept ? rx_wr_add : grant ? rd_add : '0;
      mem_wdata <= wrAccept ? rx_wr_data : '0;
      rd_ack <= grant;
      rd_valid <= rd_ack;
    end
  end
  // the RAM returns data the cycle after the read strobe, which is the rd_valid cycle
  assign rd_data = rd_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_rx_bank_arbiter.sv
// tb_rx_bank_arbiter: directed self-checking bench for rx_bank_arbiter with a short frame
module tb_rx_bank_arbiter;
  localparam logic [17:0] LAST = 18'h0000F;
  logic clk = 0, rst = 1;
  logic rx_frame_start = 0, rx_wr_y = 0, rx_wr_c = 0, rd_frame_start = 0, rd_req = 0;
  logic [17:0] rx_wr_add = '0, rd_add = '0, mem_add;
  logic [5:0] rx_wr_data = '0, rd_data, mem_wdata, mem_rdata = '0;
  logic rd_ack, rd_valid, mem_en, mem_we, mem_sel_c, mem_bank, rd_bank, frame_ready;
  logic [7:0] drop_cnt;
  int nChecks = 0, nErrors = 0;

  rx_bank_arbiter #(.LAST_ADD(LAST)) dut (
    .clk(clk), .rst(rst), .rx_frame_start(rx_frame_start), .rx_wr_y(rx_wr_y),
    .rx_wr_c(rx_wr_c), .rx_wr_add(rx_wr_add), .rx_wr_data(rx_wr_data),
    .rd_frame_start(rd_frame_start), .rd_req(rd_req), .rd_add(rd_add), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_sel_c(mem_sel_c), .mem_bank(mem_bank), .mem_add(mem_add), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_bank(rd_bank), .frame_ready(frame_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: read data is a fixed function of bank and address, one cycle after the strobe
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_add[5:0] ^ {5'b0, mem_bank} ^ 6'h2A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_sel_c", mem_sel_c, 0);
    check("rst mem_bank", mem_bank, 0);
    check("rst mem_add", mem_add, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst rd_ack", rd_ack, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_bank", rd_bank, 0);
    check("rst frame_ready", frame_ready, 0);
    check("rst drop_cnt", drop_cnt, 0);
  endtask

  task automatic doWrite(input logic y, input logic c, input logic [17:0] add, input logic [5:0] data, input logic bank);
    rx_wr_y = y;
    rx_wr_c = c;
    rx_wr_add = add;
    rx_wr_data = data;
    tick();
    rx_wr_y = 0;
    rx_wr_c = 0;
    rx_frame_start = 0;
    rd_frame_start = 0;
    check("wr mem_en", mem_en, 1);
    check("wr mem_we", mem_we, 1);
    check("wr mem_sel_c", mem_sel_c, c & ~y);
    check("wr mem_bank", mem_bank, bank);
    check("wr mem_add", mem_add, add);
    check("wr mem_wdata", mem_wdata, data);
    tick();
  endtask

  task automatic doFrame(input logic bank);
    rx_frame_start = 1;
    tick();
    rx_frame_start = 0;
    for (int i = 0; i <= int'(LAST); i++) doWrite(!i[0], i[0], 18'(i), 6'(i * 3 + 1), bank);
    check("frame ready", frame_ready, 1);
  endtask

  initial begin
    repeat (3) tick();
    checkReset();
    rst = 0;
    tick();
    rx_wr_y = 1;
    tick();
    rx_wr_y = 0;
    check("idle write ignored", mem_en, 0);
    tick();
    doFrame(1);
    check("f1 drop", drop_cnt, 0);
    check("f1 rd_bank", rd_bank, 0);
    rd_frame_start = 1;
    tick();
    rd_frame_start = 0;
    check("swap rd_bank", rd_bank, 1);
    check("swap ready", frame_ready, 0);
    doFrame(0);
    doFrame(0);
    check("f3 drop", drop_cnt, 1);
    check("f3 rd_bank", rd_bank, 1);
    rx_frame_start = 1;
    tick();
    rx_frame_start = 0;
    check("f4 drop", drop_cnt, 2);
    check("f4 ready cleared", frame_ready, 0);
    rd_req = 1;
    rd_add = 18'h00100;
    rx_wr_y = 1;
    rx_wr_add = 0;
    rx_wr_data = 6'h15;
    tick();
    rx_wr_y = 0;
    check("arb write first", mem_we, 1);
    check("arb no early ack", rd_ack, 0);
    tick();
    check("arb rd_ack", rd_ack, 1);
    check("arb rd mem_en", mem_en, 1);
    check("arb rd mem_we", mem_we, 0);
    check("arb rd mem_bank", mem_bank, 1);
    check("arb rd mem_add", mem_add, 18'h00100);
    rd_req = 0;
    tick();
    check("arb rd_valid", rd_valid, 1);
    check("arb rd_data", rd_data, 6'h2B);
    check("arb ack once", rd_ack, 0);
    tick();
    check("arb no regrant", mem_en, 0);
    for (int i = 1; i <= 5; i++) doWrite(1, 0, 18'(i), 6'(i), 0);
    rd_frame_start = 1;
    tick();
    rd_frame_start = 0;
    check("mid-frame no swap", rd_bank, 1);
    rx_frame_start = 1;
    tick();
    rx_frame_start = 0;
    check("restart drop", drop_cnt, 2);
    check("restart ready", frame_ready, 0);
    for (int i = 0; i < int'(LAST); i++) doWrite(0, 1, 18'(i), 6'(i), 0);
    rd_frame_start = 1;
    doWrite(1, 0, LAST, 6'h3F, 0);
    check("last+rdfs no swap", rd_bank, 1);
    check("last+rdfs ready", frame_ready, 1);
    rd_frame_start = 1;
    tick();
    rd_frame_start = 0;
    check("swap2 rd_bank", rd_bank, 0);
    rx_frame_start = 1;
    tick();
    rx_frame_start = 0;
    doWrite(1, 1, 0, 6'h11, 1);
    for (int i = 1; i <= 3; i++) doWrite(0, 1, 18'(i), 6'(i), 1);
    rx_wr_y = 1;
    rd_req = 1;
    rd_add = 18'h00005;
    rst = 1;
    #1;
    rx_wr_y = 0;
    checkReset();
    tick();
    rst = 0;
    tick();
    check("post-rst rd_ack", rd_ack, 1);
    check("post-rst mem_add", mem_add, 18'h00005);
    check("post-rst mem_bank", mem_bank, 0);
    rd_req = 0;
    tick();
    check("post-rst rd_valid", rd_valid, 1);
    check("post-rst rd_data", rd_data, 6'h2F);
    check("post-rst ready", frame_ready, 0);
    rx_wr_y = 1;
    tick();
    rx_wr_y = 0;
    check("post-rst writer idle", mem_en, 0);
    tick();
    doFrame(1);
    check("f6 drop", drop_cnt, 0);
    check("f6 rd_bank", rd_bank, 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
